stopwatch_datapath: RTL and testbench
=====================================

Name: stopwatch_datapath

Overview:
- Time-keeping datapath driven by the stopwatch button controller's `run_stop` and `clear` outputs. It is the consumer end of that control interface.
- Divides the system clock down to a 100 Hz count enable and keeps a cascaded hour:min:sec:centisecond count.
- Outputs are binary fields for the downstream FND/digit-split logic.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, centisecond count rate in Hz.
- DIV = CLK_FREQ/TICK_HZ, derived localparam. CLK_FREQ must be an exact multiple of TICK_HZ and DIV must be ≥ 2; anything else is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- run_stop  input  1  1 = count, 0 = hold. Level from controller, synchronous to clk.
- clear  input  1  synchronous clear request. Controller pulse, normally 1 cycle.
- o_msec  output  7  centiseconds, 0..99.
- o_sec  output  6  seconds, 0..59.
- o_min  output  6  minutes, 0..59.
- o_hour  output  5  hours, 0..23.
- o_tick  output  1  registered 1-cycle pulse on every centisecond increment.

Behaviour:
- Reset (rst=0, asynchronous): prescaler=0; o_msec=o_sec=o_min=o_hour=0; o_tick=0. Release of rst is synchronous to clk by system assumption.
- All state updates on the rising edge of clk. All outputs are registered.
- Prescaler presc, width $clog2(DIV), range 0..DIV-1:
  - clear=1: presc <= 0 (highest priority).
  - else run_stop=1 and presc==DIV-1: presc <= 0, and tick is asserted for this edge.
  - else run_stop=1: presc <= presc+1.
  - else (run_stop=0): presc holds. A paused fraction is preserved; it is not discarded.
- Latency: after clear or reset, the first o_msec increment lands on the DIV-th rising edge with run_stop=1. run_stop=0 cycles in between do not count.
- Counter cascade, all four fields update on the same edge; there is no ripple delay:
  - msec: on tick, wraps 99→0 and generates carry_s; otherwise +1.
  - sec: on carry_s, wraps 59→0 and generates carry_m.
  - min: on carry_m, wraps 59→0 and generates carry_h.
  - hour: on carry_h, wraps 23→0. There is no overflow flag; 23:59:59.99 + tick = 00:00:00.00.
  - Carries are combinational from current value == MAX and the incoming enable.
- o_tick <= tick, so it is high in the cycle after each increment edge. Forced 0 when clear=1.
- clear=1 (synchronous), regardless of run_stop: next edge sets all fields and presc to 0, with no tick.
  - If clear stays high, the block holds at zero.
  - Counting resumes from presc=0 on the first edge with clear=0 and run_stop=1.
- Simultaneous clear and tick condition: clear wins and no increment occurs.
- run_stop toggling mid-count has no effect on the fields other than freezing presc. Fields never change while run_stop=0.
- Reset mid-operation: immediate asynchronous zeroing of all state. Same post-reset behaviour as power-up.
- Out-of-range values are unreachable. Implementation must still wrap on `>= MAX` rather than `== MAX` for robustness.

Decomposition:
- Shared package stopwatch_pkg:
  - constants MSEC_MAX=100, SEC_MAX=60, MIN_MAX=60, HOUR_MAX=24.
  - field widths MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5.
  - Reused later by the display splitter and the clock/time-set blocks.
- Natural sub-module: time_counter.
  - Parameters MAX, W.
  - Ports clk, rst, clear, en; outputs cnt[W-1:0] and combinational carry = en & (cnt==MAX-1).
  - Instantiated 4 times in a chain; the prescaler stays inline in stopwatch_datapath.

Test Plan (CLK_FREQ=1000, TICK_HZ=100 → DIV=10):
- rst=0 mid-run with msec=37 → all outputs 0 immediately (before the next edge), o_tick=0; after release with run_stop=0 for 50 cycles → still 0.
- clear pulse, then run_stop=1 for exactly 10 edges → o_msec=1 after edge 10, o_tick high one cycle after edge 10; 9 edges alone → o_msec=0.
- Run 5 edges, run_stop=0 for 20 edges, run 5 edges → o_msec becomes 1 exactly on the 10th counted edge; no change during the pause.
- Preload via run to 00:00:00.99, one more tick → o_msec=0, o_sec=1 on the same edge; similarly 00:00:59.99 → 00:01:00.00.
- Run to 23:59:59.99, one more tick → 00:00:00.00 on the same edge, no X or glitch on any field.
- clear=1 asserted on the edge where presc==9 with run_stop=1 and msec=42 → next state all zeros, presc=0, o_tick=0. Then clear=0, run 10 edges → msec=1.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared time-keeping constants for the stopwatch datapath, display splitter and
// clock/time-set blocks.
package stopwatch_pkg;

  localparam int unsigned MSEC_MAX = 100;
  localparam int unsigned SEC_MAX  = 60;
  localparam int unsigned MIN_MAX  = 60;
  localparam int unsigned HOUR_MAX = 24;

  localparam int unsigned MSEC_W = 7;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

endpackage

// File: rtl/time_counter.sv
// Modulo-MAX counter stage with synchronous clear and a combinational carry out,
// chained to build the centisecond/second/minute/hour cascade.
module time_counter #(
  parameter int unsigned MAX = 10,
  parameter int unsigned W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         carry
);

  localparam logic [W-1:0] Last = W'(MAX - 1);

  logic [W-1:0] cnt_d, cnt_q;

  // Wrap on >= so a corrupted out-of-range value recovers on the next increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q >= Last) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt   = cnt_q;
  assign carry = en & (cnt_q == Last);

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch time base: prescales clk to a centisecond tick and runs the
// hour:min:sec:centisecond cascade under run_stop/clear control.
module stopwatch_datapath
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned TICK_HZ  = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_stop,
  input  logic              clear,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick
);

  localparam int unsigned DIV = (TICK_HZ == 0) ? 0 : CLK_FREQ / TICK_HZ;
  localparam int unsigned PW  = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if (TICK_HZ == 0 || (CLK_FREQ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
      $error("stopwatch_datapath: CLK_FREQ must be an exact multiple of TICK_HZ with DIV >= 2");
    end
  endgenerate

  localparam logic [PW-1:0] PrescLast = PW'(DIV - 1);

  logic [PW-1:0] presc_d, presc_q;
  logic          tick;
  logic          o_tick_d, o_tick_q;
  logic          carry_s, carry_m, carry_h;
  logic          hour_carry_unused;

  // A paused fraction stays in presc; only clear discards it.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (clear) begin
      presc_d = '0;
    end else if (run_stop) begin
      if (presc_q >= PrescLast) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    o_tick_d = tick;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      o_tick_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      o_tick_q <= o_tick_d;
    end
  end

  assign o_tick = o_tick_q;

  time_counter #(
    .MAX (MSEC_MAX),
    .W   (MSEC_W)
  ) u_msec (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (tick),
    .cnt   (o_msec),
    .carry (carry_s)
  );

  time_counter #(
    .MAX (SEC_MAX),
    .W   (SEC_W)
  ) u_sec (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (carry_s),
    .cnt   (o_sec),
    .carry (carry_m)
  );

  time_counter #(
    .MAX (MIN_MAX),
    .W   (MIN_W)
  ) u_min (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (carry_m),
    .cnt   (o_min),
    .carry (carry_h)
  );

  time_counter #(
    .MAX (HOUR_MAX),
    .W   (HOUR_W)
  ) u_hour (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (carry_h),
    .cnt   (o_hour),
    .carry (hour_carry_unused)
  );

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Directed scoreboard bench for stopwatch_datapath with DIV = 10.
module tb_stopwatch_datapath;

  localparam int unsigned DIV = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_stop;
  logic       clear;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;

  stopwatch_datapath #(
    .CLK_FREQ (1000),
    .TICK_HZ  (100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run_stop (run_stop),
    .clear    (clear),
    .o_msec   (o_msec),
    .o_sec    (o_sec),
    .o_min    (o_min),
    .o_hour   (o_hour),
    .o_tick   (o_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [24:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec  = 0;
  int  n_fail = 0;

  int   m_presc, m_ms, m_s, m_m, m_h;
  logic m_tick;

  task automatic model_zero();
    m_presc = 0; m_ms = 0; m_s = 0; m_m = 0; m_h = 0; m_tick = 1'b0;
  endtask

  function automatic logic [24:0] model_vec();
    return {5'(m_h), 6'(m_m), 6'(m_s), 7'(m_ms), m_tick};
  endfunction

  task automatic model_advance();
    if (m_ms == 99) begin
      m_ms = 0;
      if (m_s == 59) begin
        m_s = 0;
        if (m_m == 59) begin
          m_m = 0;
          m_h = (m_h == 23) ? 0 : m_h + 1;
        end else m_m++;
      end else m_s++;
    end else m_ms++;
  endtask

  task automatic model_edge(input logic rs, input logic clr);
    m_tick = 1'b0;
    if (clr) begin
      model_zero();
    end else if (rs) begin
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        m_tick  = 1'b1;
        model_advance();
      end else begin
        m_presc++;
      end
    end
  endtask

  task automatic expect_now(input string tag);
    sb_q.push_back('{tag, model_vec()});
  endtask

  task automatic check_head();
    sb_t         e;
    logic [24:0] obs;
    obs = {o_hour, o_min, o_sec, o_msec, o_tick};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d:%0d:%0d.%0d tick=%b, expected %0d:%0d:%0d.%0d tick=%b",
             e.tag, obs[24:20], obs[19:14], obs[13:8], obs[7:1], obs[0],
             e.exp[24:20], e.exp[19:14], e.exp[13:8], e.exp[7:1], e.exp[0]);
    end
  endtask

  // Called at posedge+1; applies inputs for exactly one rising edge and checks after it.
  task automatic step(input logic rs, input logic clr, input string tag);
    run_stop = rs;
    clear    = clr;
    model_edge(rs, clr);
    expect_now(tag);
    @(posedge clk);
    #1;
    check_head();
  endtask

  initial begin
    rst      = 1'b0;
    run_stop = 1'b0;
    clear    = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    expect_now("reset_state");
    check_head();
    rst = 1'b1;

    // First increment lands on the 10th counted edge.
    step(1'b0, 1'b1, "clr_pulse");
    repeat (9) step(1'b1, 1'b0, "latency_9");
    step(1'b1, 1'b0, "latency_10");
    step(1'b0, 1'b0, "tick_fall");

    // A pause keeps the partial prescale count.
    step(1'b0, 1'b1, "clr_pause");
    repeat (5) step(1'b1, 1'b0, "pause_pre");
    repeat (20) step(1'b0, 1'b0, "pause_hold");
    repeat (5) step(1'b1, 1'b0, "pause_post");

    // Asynchronous reset mid-run.
    for (int i = 0; i < 2000 && m_ms != 37; i++) step(1'b1, 1'b0, "run_to_37");
    run_stop = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    model_zero();
    expect_now("async_rst");
    check_head();
    @(posedge clk);
    #1;
    expect_now("rst_held");
    check_head();
    rst = 1'b1;
    repeat (50) step(1'b0, 1'b0, "post_rst_idle");

    // Clear coinciding with a tick edge wins.
    step(1'b0, 1'b1, "clr_collide");
    for (int i = 0; i < 2000 && !(m_ms == 42 && m_presc == DIV - 1); i++)
      step(1'b1, 1'b0, "run_to_42");
    step(1'b1, 1'b1, "clear_vs_tick");
    repeat (10) step(1'b1, 1'b0, "after_clear");

    // Natural run through 00:00:00.99 and up to 00:00:59.99.
    step(1'b0, 1'b1, "clr_long");
    for (int i = 0; i < 70000 && !(m_s == 59 && m_ms == 99 && m_presc == DIV - 1); i++)
      step(1'b1, 1'b0, "run_to_59s");
    step(1'b1, 1'b0, "sec_to_min");

    // Preload 23:59:59.99 with run_stop low so each stage reloads its own value.
    step(1'b0, 1'b1, "clr_preload");
    run_stop = 1'b0;
    clear    = 1'b0;
    force dut.u_msec.cnt_q = 7'd99;
    force dut.u_sec.cnt_q  = 6'd59;
    force dut.u_min.cnt_q  = 6'd59;
    force dut.u_hour.cnt_q = 5'd23;
    m_ms = 99; m_s = 59; m_m = 59; m_h = 23; m_tick = 1'b0;
    expect_now("preload");
    @(posedge clk);
    #1;
    release dut.u_msec.cnt_q;
    release dut.u_sec.cnt_q;
    release dut.u_min.cnt_q;
    release dut.u_hour.cnt_q;
    check_head();
    step(1'b0, 1'b0, "preload_hold");
    repeat (9) step(1'b1, 1'b0, "wrap_pre");
    step(1'b1, 1'b0, "day_wrap");
    step(1'b0, 1'b0, "day_wrap_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
